// File: rtl/wram_pkg.sv
// Shared types and widths for the S-WRAM external-memory bridge.
package wram_pkg;

    localparam int unsigned WRAM_AW = 17;
    localparam int unsigned WRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FILL
    } state_t;

    typedef struct packed {
        logic               we;
        logic [WRAM_AW-1:0] addr;
        logic [WRAM_DW-1:0] wdata;
    } access_t;

endpackage

// File: rtl/wram_strobe_edge.sv
// Registered falling-edge detector for the WRAM read/write strobes, qualified
// by chip enable. A strobe held low produces a single start only.
module wram_strobe_edge (
    input  logic CLK,
    input  logic RST_N,
    input  logic ce_n,
    input  logic rd_n,
    input  logic we_n,
    output logic rd_start,
    output logic wr_start
);

    logic rd_n_q, rd_n_d;
    logic we_n_q, we_n_d;

    always_comb begin
        rd_n_d = rd_n;
        we_n_d = we_n;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_n_q <= 1'b1;
            we_n_q <= 1'b1;
        end else begin
            rd_n_q <= rd_n_d;
            we_n_q <= we_n_d;
        end
    end

    always_comb begin
        rd_start = ~rd_n & rd_n_q & ~ce_n;
        wr_start = ~we_n & we_n_q & ~ce_n;
    end

endmodule

// File: rtl/wram_mem_bridge.sv
// WRAM strobe interface to external memory request/ack bridge with a one-deep
// pending slot. Define WRAM_INIT_EN to add the post-reset INIT_VAL fill sweep.
module wram_mem_bridge
    import wram_pkg::*;
#(
    parameter int unsigned    AW       = WRAM_AW,
    parameter int unsigned    DW       = WRAM_DW,
    parameter logic [DW-1:0]  INIT_VAL = 8'h55
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW-1:0] RAM_A,
    input  logic [DW-1:0] RAM_D,
    input  logic          RAM_CE_N,
    input  logic          RAM_RD_N,
    input  logic          RAM_WE_N,
    output logic [DW-1:0] RAM_Q,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic          MEM_ACK,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          BUSY,
    output logic          OVERRUN
);

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    access_t       mem_acc_q, mem_acc_d;
    logic [DW-1:0] ram_q_q, ram_q_d;
    logic          pend_valid_q, pend_valid_d;
    access_t       pend_q, pend_d;
    logic          overrun_q, overrun_d;
    access_t       wr_acc, rd_acc, new_acc;
    logic          rd_start, wr_start;
`ifdef WRAM_INIT_EN
    logic [AW-1:0] fill_addr_q, fill_addr_d;
`endif

    wram_strobe_edge u_edge (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ce_n     (RAM_CE_N),
        .rd_n     (RAM_RD_N),
        .we_n     (RAM_WE_N),
        .rd_start (rd_start),
        .wr_start (wr_start)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
`ifdef WRAM_INIT_EN
            state_q <= FILL;
`else
            state_q <= IDLE;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pend_valid_q || rd_start || wr_start) state_d = WAIT;
            WAIT: if (MEM_ACK) state_d = IDLE;
`ifdef WRAM_INIT_EN
            FILL: if (MEM_ACK && (fill_addr_q == '1)) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous write+read issues the write; the read takes the pending slot.
    always_comb begin
        wr_acc       = '{we: 1'b1, addr: RAM_A, wdata: RAM_D};
        rd_acc       = '{we: 1'b0, addr: RAM_A, wdata: RAM_D};
        new_acc      = wr_start ? wr_acc : rd_acc;
        mem_req_d    = mem_req_q;
        mem_acc_d    = mem_acc_q;
        ram_q_d      = ram_q_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        overrun_d    = overrun_q;
`ifdef WRAM_INIT_EN
        fill_addr_d  = fill_addr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    mem_req_d    = 1'b1;
                    mem_acc_d    = pend_q;
                    pend_valid_d = wr_start | rd_start;
                    pend_d       = new_acc;
                    overrun_d    = overrun_q | (wr_start & rd_start);
                end else if (wr_start || rd_start) begin
                    mem_req_d    = 1'b1;
                    mem_acc_d    = new_acc;
                    pend_valid_d = wr_start & rd_start;
                    pend_d       = rd_acc;
                end
            end
            WAIT: begin
                if (wr_start || rd_start) begin
                    if (pend_valid_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_d       = new_acc;
                        overrun_d    = overrun_q | (wr_start & rd_start);
                    end
                end
                if (MEM_ACK) begin
                    mem_req_d = 1'b0;
                    if (!mem_acc_q.we) ram_q_d = MEM_RDATA;
                end
            end
`ifdef WRAM_INIT_EN
            // Address advances on each ACK so the held request always names the next word.
            FILL: begin
                if (MEM_ACK) fill_addr_d = fill_addr_q + 1'b1;
                mem_req_d = !(MEM_ACK && (fill_addr_q == '1));
                mem_acc_d = '{we: 1'b1, addr: fill_addr_d, wdata: INIT_VAL};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_req_q    <= 1'b0;
            mem_acc_q    <= '0;
            ram_q_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            overrun_q    <= 1'b0;
`ifdef WRAM_INIT_EN
            fill_addr_q  <= '0;
`endif
        end else begin
            mem_req_q    <= mem_req_d;
            mem_acc_q    <= mem_acc_d;
            ram_q_q      <= ram_q_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
`ifdef WRAM_INIT_EN
            fill_addr_q  <= fill_addr_d;
`endif
        end
    end

    always_comb begin
        MEM_REQ   = mem_req_q;
        MEM_WE    = mem_acc_q.we;
        MEM_ADDR  = mem_acc_q.addr;
        MEM_WDATA = mem_acc_q.wdata;
        RAM_Q     = ram_q_q;
        OVERRUN   = overrun_q;
        BUSY      = (state_q != IDLE) | pend_valid_q;
    end

endmodule

// File: tb/tb_wram_mem_bridge.sv
// Directed and randomized checks of wram_mem_bridge against an arrival-order
// queue model of accepted accesses and a sparse memory model.
module tb_wram_mem_bridge;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [16:0] RAM_A;
    logic [7:0]  RAM_D;
    logic        RAM_CE_N;
    logic        RAM_RD_N;
    logic        RAM_WE_N;
    logic [7:0]  RAM_Q;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [16:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_ACK;
    logic [7:0]  MEM_RDATA;
    logic        BUSY;
    logic        OVERRUN;

    wram_mem_bridge #(.AW(17), .DW(8), .INIT_VAL(8'h55)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RAM_A     (RAM_A),
        .RAM_D     (RAM_D),
        .RAM_CE_N  (RAM_CE_N),
        .RAM_RD_N  (RAM_RD_N),
        .RAM_WE_N  (RAM_WE_N),
        .RAM_Q     (RAM_Q),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .BUSY      (BUSY),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wdata;
    } acc_t;

    // Model: accepted accesses in arrival order; head is the one being served.
    acc_t        fifo[$];
    logic [7:0]  mem[logic [16:0]];
    logic [7:0]  exp_ramq;
    logic        exp_ovr;
    logic        prev_rd, prev_we;
    int unsigned ack_lat;
    int unsigned req_age;
    int unsigned req_rises;
    logic        last_req;
    logic        force_ack;
    int unsigned vectors = 0;
    int unsigned fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [16:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hC3;
    endfunction

    // Two accesses may be outstanding: one in flight, one waiting.
    task automatic accept(input logic we, input logic [16:0] a, input logic [7:0] d);
        acc_t e;
        if (fifo.size() >= 2) begin
            exp_ovr = 1'b1;
        end else begin
            e.we = we; e.addr = a; e.wdata = d;
            fifo.push_back(e);
        end
    endtask

    task automatic step(input logic rd_n, input logic we_n, input logic ce_n,
                        input logic [16:0] a, input logic [7:0] d);
        logic ack, rs, ws;
        acc_t h;
        RAM_RD_N = rd_n;
        RAM_WE_N = we_n;
        RAM_CE_N = ce_n;
        RAM_A    = a;
        RAM_D    = d;
        if (MEM_REQ === 1'b1) req_age++; else req_age = 0;
        ack = (MEM_REQ === 1'b1) && (req_age > ack_lat);
        if (force_ack && MEM_REQ !== 1'b1) begin
            MEM_ACK   = 1'b1;
            MEM_RDATA = 8'hEE;
        end else begin
            MEM_ACK   = ack;
            MEM_RDATA = (MEM_WE === 1'b1) ? 8'($urandom) : mem_rd(MEM_ADDR);
        end
        ws = !we_n && prev_we && !ce_n;
        rs = !rd_n && prev_rd && !ce_n;
        prev_we = we_n;
        prev_rd = rd_n;
        if (ws) accept(1'b1, a, d);
        if (rs) accept(1'b0, a, d);
        if (ack) begin
            if (fifo.size() == 0) begin
                chk("req_without_access", 32'd1, 32'd0);
            end else begin
                h = fifo.pop_front();
                chk("req_we", MEM_WE, h.we);
                chk("req_addr", MEM_ADDR, h.addr);
                if (h.we) begin
                    chk("req_wdata", MEM_WDATA, h.wdata);
                    mem[h.addr] = h.wdata;
                end else begin
                    exp_ramq = mem_rd(h.addr);
                end
            end
        end
        @(posedge CLK);
        #1;
        MEM_ACK = 1'b0;
        if (ack) req_age = 0;
        if (MEM_REQ === 1'b1 && !last_req) req_rises++;
        last_req = (MEM_REQ === 1'b1);
        chk("busy", BUSY, fifo.size() != 0);
        chk("overrun", OVERRUN, exp_ovr);
        chk("ram_q", RAM_Q, exp_ramq);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((fifo.size() != 0 || MEM_REQ === 1'b1) && n < 100) begin
            idle();
            n++;
        end
        chk(tag, fifo.size(), 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        RAM_RD_N = 1'b1; RAM_WE_N = 1'b1; RAM_CE_N = 1'b1;
        RAM_A = '0; RAM_D = '0;
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        fifo.delete();
        exp_ramq = 8'h00; exp_ovr = 1'b0;
        prev_rd = 1'b1; prev_we = 1'b1;
        req_age = 0; last_req = 1'b0;
        chk("rst_req", MEM_REQ, 0);
        chk("rst_we", MEM_WE, 0);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_wdata", MEM_WDATA, 0);
        chk("rst_ram_q", RAM_Q, 8'h00);
        chk("rst_busy", BUSY, 0);
        chk("rst_overrun", OVERRUN, 0);
    endtask

    initial begin
        int unsigned r0;
        logic [16:0] ra;
        force_ack = 1'b0;
        ack_lat = 3;
        req_rises = 0;
        mem[17'h1FFFF] = 8'h3C;
        do_reset();

        // Single write, request visible one cycle after the strobe edge
        step(1'b1, 1'b0, 1'b0, 17'h00123, 8'hA5);
        chk("wr_req_latency", MEM_REQ, 1);
        chk("wr_we", MEM_WE, 1);
        chk("wr_addr", MEM_ADDR, 17'h00123);
        chk("wr_wdata", MEM_WDATA, 8'hA5);
        drain("wr_drain");
        chk("wr_req_done", MEM_REQ, 0);
        chk("wr_busy_done", BUSY, 0);

        // Read at the top address, then a write must not disturb RAM_Q
        step(1'b0, 1'b1, 1'b0, 17'h1FFFF, 8'h00);
        drain("rd_drain");
        chk("rd_top_data", RAM_Q, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 17'h1FFFF, 8'h99);
        drain("wr_after_rd_drain");
        chk("ram_q_hold", RAM_Q, 8'h3C);

        // Write then read of the same address while the write is outstanding
        ack_lat = 2;
        step(1'b1, 1'b0, 1'b0, 17'h00010, 8'h77);
        idle();
        step(1'b0, 1'b1, 1'b0, 17'h00010, 8'h00);
        drain("b2b_drain");
        chk("b2b_data", RAM_Q, 8'h77);

        // Three starts against one in-flight request
        ack_lat = 6;
        r0 = req_rises;
        step(1'b1, 1'b0, 1'b0, 17'h00020, 8'h01);
        idle();
        step(1'b1, 1'b0, 1'b0, 17'h00021, 8'h02);
        idle();
        step(1'b1, 1'b0, 1'b0, 17'h00022, 8'h03);
        drain("ovf_drain");
        chk("ovf_req_count", req_rises - r0, 2);
        chk("ovf_sticky", OVERRUN, 1);
        repeat (3) idle();
        chk("ovf_sticky_later", OVERRUN, 1);
        do_reset();

        // Simultaneous strobes: write first, then the read returns it
        ack_lat = 1;
        step(1'b0, 1'b0, 1'b0, 17'h00030, 8'hE1);
        drain("sim_drain");
        chk("sim_order_data", RAM_Q, 8'hE1);
        chk("sim_no_overrun", OVERRUN, 0);

        // Read strobe held low for 10 cycles
        r0 = req_rises;
        repeat (10) step(1'b0, 1'b1, 1'b0, 17'h00031, 8'h00);
        drain("held_drain");
        chk("held_req_count", req_rises - r0, 1);

        // Reset mid-transaction, then a stale ACK
        ack_lat = 10;
        step(1'b1, 1'b0, 1'b0, 17'h00040, 8'h44);
        idle();
        idle();
        do_reset();
        force_ack = 1'b1;
        idle();
        force_ack = 1'b0;
        chk("stale_ack_req", MEM_REQ, 0);
        chk("stale_ack_busy", BUSY, 0);
        chk("stale_ack_ram_q", RAM_Q, 8'h00);
        idle();
        chk("stale_ack_req_later", MEM_REQ, 0);

        // Randomized strobes and ACK latencies
        for (int i = 0; i < 400; i++) begin
            ack_lat = $urandom_range(0, 4);
            ra = 17'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) ra[16] = 1'b1;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), ra, 8'($urandom));
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/wram_mem_bridge.md
Name: wram_mem_bridge

Overview:
- Downstream stage of the S-WRAM access logic: converts the WRAM strobe interface (RAM_A/RAM_D/RAM_CE_N/RAM_RD_N/RAM_WE_N) into request/acknowledge transactions to the shared external memory controller.
- Returns read data on RAM_Q.
- Edge-detects CPU and B-bus strobes and tracks each access through a small state machine.
- Holds one extra access in a one-deep pending slot while the controller is busy.

Parameters:
- AW, 17, WRAM byte address width (128 KB).
- DW, 8, data width.
- INIT_VAL, 8'h55, fill byte written by the power-on fill sweep (used only with WRAM_INIT_EN).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- RAM_A  in  AW  access address from WRAM logic.
- RAM_D  in  DW  write data.
- RAM_CE_N  in  1  chip enable, active low.
- RAM_RD_N  in  1  read-cycle strobe, active low.
- RAM_WE_N  in  1  write strobe, active low.
- RAM_Q  out  DW  last read data.
- MEM_REQ  out  1  request valid, level.
- MEM_WE  out  1  1 = write, 0 = read.
- MEM_ADDR  out  AW  request address.
- MEM_WDATA  out  DW  request write data.
- MEM_ACK  in  1  one-cycle completion pulse.
- MEM_RDATA  in  DW  read data, valid with MEM_ACK.
- BUSY  out  1  transaction outstanding or fill sweep active.
- OVERRUN  out  1  sticky: an access was dropped.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - State goes to IDLE.
  - MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, RAM_Q=8'h00, BUSY=0, OVERRUN=0.
  - Pending slot empties; strobe history registers set to 1.
- Start detection (on CLK edges only):
  - Read start: RAM_RD_N=0 and registered previous RAM_RD_N=1 and RAM_CE_N=0.
  - Write start: the same rule on RAM_WE_N.
  - If both start in the same cycle, the write is taken and the read is captured into the pending slot.
  - A strobe held low continuously (e.g. ENABLE=0 forcing RD_N low) generates no new starts.
- Capture: RAM_A, RAM_D and the direction are latched at the detection cycle. Later changes on these inputs are ignored.
- State machine:
  - IDLE: on a start, or when the pending slot is valid (pending has priority over a new start, which then enters pending), drive MEM_* with the latched access. MEM_REQ=1 on the next cycle. Go to WAIT.
  - WAIT: MEM_REQ and all MEM_* fields are held stable until MEM_ACK=1. On ACK:
    - MEM_REQ drops.
    - On a read, RAM_Q <= MEM_RDATA, visible the cycle after ACK.
    - Return to IDLE. Pending is issued on the following cycle, giving one idle cycle between requests.
  - FILL: exists only with WRAM_INIT_EN.
- Latency: strobe edge sampled at cycle N → MEM_REQ=1 at N+1 → RAM_Q updated at ACK+1.
- Pending slot and overflow:
  - A start arriving in WAIT fills the empty pending slot.
  - If the slot is full, the access is dropped and OVERRUN is set. OVERRUN clears only on reset.
- MEM_ACK handling: ignored in IDLE, so a stale ACK after reset is harmless.
- Ordering: accesses issue strictly in arrival order, so a write followed by a read to the same address returns the written data.
- RAM_Q: holds its value between reads. Writes never change it.
- BUSY = (state != IDLE) | pending valid.

Optional Feature:
- Macro: WRAM_INIT_EN.
- Defined:
  - After reset, the FSM enters FILL and issues writes of INIT_VAL to addresses 0 to 2^AW−1, ascending, one per ACK.
  - BUSY=1 throughout.
  - WRAM strobes seen during FILL are dropped and do not set OVERRUN.
  - Goes to IDLE after the ACK for the last address (17'h1FFFF).
  - Reset mid-fill restarts the sweep from address 0.
- Undefined: no FILL state. The FSM enters IDLE directly after reset.

Decomposition:
- Shared package wram_pkg:
  - WRAM_AW=17, WRAM_DW=8.
  - State enum {IDLE, WAIT, FILL}.
  - Access record type {we, addr, wdata}.
- One sub-module: wram_strobe_edge (registered falling-edge detector for RD_N/WE_N, qualified by CE_N), instantiated once.

Test Plan:
- Write start: RAM_A=17'h00123, RAM_D=8'hA5, WE_N falls → MEM_REQ=1 next cycle with MEM_WE=1, ADDR=00123, WDATA=A5. ACK after 3 cycles → REQ=0, BUSY=0.
- Read: RD_N falls at A=17'h1FFFF; ACK with MEM_RDATA=8'h3C → RAM_Q=3C one cycle after ACK. RAM_Q unchanged by a later write.
- Back-to-back: write 17'h10=8'h77 then read 17'h10 issued during WAIT → pending; requests issue in order; RAM_Q=77 (memory model).
- Overflow: three starts during one WAIT → third dropped, OVERRUN=1 stays set. Exactly two requests issued.
- Simultaneous RD_N and WE_N fall → write requested first, read second. Held-low RD_N for 10 cycles → exactly one request.
- Reset mid-WAIT, then late ACK pulse → REQ=0, RAM_Q=00, no state change. With WRAM_INIT_EN, 131072 writes of 8'h55 are issued and BUSY deasserts after the last.
